// File: rtl/pipe_subtractor.sv
// -----------------------------------------------------------------------------
// pipe_subtractor
//
// Pipelined unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), with
// bout = 1 when a < b + bin. The operand width is cut into STAGES chunks of
// CW = WIDTH/STAGES bits. Each pipeline stage resolves one chunk with the
// full-subtractor bit rule and registers the borrow for the next stage.
// The pipe streams one operation per cycle behind a valid/ready handshake.
// Empty stages (bubbles) collapse while the output is stalled.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES (default 16)
//   STAGES  pipeline depth, >= 1 (default 4)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every stage
//   in_valid   operand set presented
//   in_ready   operand set accepted this cycle (combinational from out_ready)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result presented (last stage valid)
//   out_ready  consumer accepts the result
//   diff       result, driven from last-stage registers only
//   bout       borrow out of the most significant chunk
//
// Build option
//   PIPE_SUB_SAT_EN  when defined, diff clamps to 0 whenever bout is 1
//                    (unsigned saturation). bout, latency and handshake are
//                    unchanged. When undefined, diff wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module pipe_subtractor #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = WIDTH / STAGES;

    // One CW-bit chunk of a - b - c, rippled bit by bit with the
    // full-subtractor identity. Returns {borrow_out, difference}.
    function automatic logic [CW:0] sub_chunk(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic          c
    );
        logic [CW-1:0] d;
        logic          brw;
        d   = '0;
        brw = c;
        for (int i = 0; i < CW; i++) begin
            d[i] = x[i] ^ y[i] ^ brw;
            brw  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & brw);
        end
        return {brw, d};
    endfunction

    // -------------------------------------------------------------------------
    // Stage state
    //
    // w_reg[k] is a rotating word. Stage 0 stores {d0, a[WIDTH-1:CW]}; every
    // later stage consumes the low CW bits (the next pending chunk of a) and
    // pushes its own result chunk in at the top. After STAGES rotations the
    // word is exactly {d[STAGES-1], ..., d[0]}, i.e. the finished difference,
    // so results and pending minuend bits share one register per stage.
    //
    // bw_reg[k] holds the not-yet-consumed subtrahend bits, shifted down so
    // the next chunk always sits in the low CW bits.
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] v_reg;
    logic [STAGES-1:0] br_reg;
    logic [WIDTH-1:0]  w_reg  [STAGES];
    logic [WIDTH-1:0]  bw_reg [STAGES];

    // Per-stage inputs (from the operand port or the previous stage)
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_borrow;
    logic [WIDTH-1:0]  src_w  [STAGES];
    logic [WIDTH-1:0]  src_b  [STAGES];

    // Per-stage chunk results and the values the stage would load
    logic [CW-1:0]     chunk_d    [STAGES];
    logic [STAGES-1:0] chunk_bout;
    logic [WIDTH-1:0]  w_next     [STAGES];
    logic [WIDTH-1:0]  bw_next    [STAGES];

    // ready[k]: stage k may load this cycle; ready[STAGES] is the consumer
    logic [STAGES:0]   ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_valid[gi]  = in_valid;
                assign up_borrow[gi] = bin;
                assign src_w[gi]     = a;
                assign src_b[gi]     = b;
            end else begin : g_body
                assign up_valid[gi]  = v_reg[gi-1];
                assign up_borrow[gi] = br_reg[gi-1];
                assign src_w[gi]     = w_reg[gi-1];
                assign src_b[gi]     = bw_reg[gi-1];
            end

            assign {chunk_bout[gi], chunk_d[gi]} =
                sub_chunk(src_w[gi][CW-1:0], src_b[gi][CW-1:0], up_borrow[gi]);

            // Rotate: drop the consumed minuend chunk, insert the result chunk
            // at the top. With STAGES == 1 this reduces to the chunk result.
            assign w_next[gi]  = WIDTH'({chunk_d[gi], src_w[gi]} >> CW);
            assign bw_next[gi] = src_b[gi] >> CW;
        end
    endgenerate

    // Bubble-collapsing ready chain, evaluated from the output backwards.
    // A stage can accept when it is empty or when its content moves on.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !v_reg[k] | ready[k+1];
        end
    end

    // Pipeline registers. A ready stage takes its upstream valid bit: it
    // loads new data when upstream is valid and otherwise becomes a bubble
    // because its previous content has just been taken downstream. A stage
    // that is not ready holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg  <= '0;
            br_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                w_reg[k]  <= '0;
                bw_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    v_reg[k] <= up_valid[k];
                    if (up_valid[k]) begin
                        br_reg[k] <= chunk_bout[k];
                        w_reg[k]  <= w_next[k];
                        bw_reg[k] <= bw_next[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_reg[STAGES-1];
    assign bout      = br_reg[STAGES-1];

`ifdef PIPE_SUB_SAT_EN
    // Unsigned saturation: any overall borrow means the true result is
    // negative, so the output clamps to zero.
    assign diff = br_reg[STAGES-1] ? '0 : w_reg[STAGES-1];
`else
    assign diff = w_reg[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipe_subtractor
//
// Self-checking bench for pipe_subtractor (WIDTH=16, STAGES=4 main instance,
// plus side instances STAGES=1/2/16 at WIDTH=16 and an exhaustive WIDTH=4,
// STAGES=2 instance). Expected results come from plain integer arithmetic
// kept in a queue in acceptance order. Honours PIPE_SUB_SAT_EN if defined.
// -----------------------------------------------------------------------------
module tb_pipe_subtractor;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;

    int errors = 0;
    int checks = 0;

    logic [W:0]   exp_q [$];
    logic [W:0]   exp_e;
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_d;
    logic         stall_bo;
    int           nout = 0;

    logic sweep_go  = 1'b0;
    logic rand_done = 1'b0;

    always #5 clk = ~clk;

    pipe_subtractor #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer difference, then wrap or clamp.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int           r;
        logic [W-1:0] d;
        logic         bo;
        r  = int'(x) - int'(y) - int'(c);
        bo = (r < 0);
        d  = W'(r);
`ifdef PIPE_SUB_SAT_EN
        if (bo) d = '0;
`endif
        return {bo, d};
    endfunction

    // Output monitor / scoreboard for the main instance
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_diff", 32'(diff), 32'(stall_d));
                    check("stall_bout", 32'(bout), 32'(stall_bo));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", 32'd1, 32'd0);
                    end else begin
                        exp_e = exp_q.pop_front();
                        $display("out %0d: diff=0x%04h bout=%0b", nout, diff, bout);
                        nout++;
                        check("out_diff", 32'(diff), 32'(exp_e[W-1:0]));
                        check("out_bout", 32'(bout), 32'(exp_e[W]));
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_d    = diff;
                stall_bo   = bout;
                if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
            end
        end
    end

    task automatic new_op();
        a   = W'($urandom);
        b   = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        bin = 1'($urandom_range(0, 1));
    endtask

    // Entered at posedge+1; checks latency and the final value directly.
    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic [W-1:0] ed, input logic eb);
        out_ready = 1'b1;
        a = x; b = y; bin = c;
        in_valid = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i < S; i++) begin
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Side instances: other geometries, always-ready consumer
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : cfg
            localparam int XW = (gi == 3) ? 4 : 16;
            localparam int XS = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 16 : 2;
            logic [XW-1:0] xa, xb, xd, dd;
            logic          xbin, xiv, xir, xov, xbo;
            logic          done = 1'b0;
            logic [XW:0]   q [$];
            logic [XW:0]   e;
            int            r;
            int            n;

            pipe_subtractor #(.WIDTH(XW), .STAGES(XS)) u_x (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (xiv),
                .in_ready  (xir),
                .a         (xa),
                .b         (xb),
                .bin       (xbin),
                .out_valid (xov),
                .out_ready (1'b1),
                .diff      (xd),
                .bout      (xbo)
            );

            initial begin
                xiv = 1'b0; xa = '0; xb = '0; xbin = 1'b0;
                wait (sweep_go);
                @(posedge clk); #1;
                n = (gi == 3) ? 512 : 200;
                for (int i = 0; i < n; i++) begin
                    if (gi == 3) begin
                        xa   = XW'(i >> 5);
                        xb   = XW'(i >> 1);
                        xbin = 1'(i & 1);
                    end else begin
                        xa   = XW'($urandom);
                        xb   = XW'($urandom);
                        xbin = 1'($urandom_range(0, 1));
                    end
                    xiv = 1'b1;
                    @(posedge clk); #1;
                end
                xiv = 1'b0;
                repeat (XS + 3) @(posedge clk);
                #1;
                check($sformatf("cfg%0d_drain", gi), 32'(q.size()), 32'd0);
                done = 1'b1;
            end

            initial begin
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (xiv) check($sformatf("cfg%0d_in_ready", gi), 32'(xir), 32'd1);
                        if (xov) begin
                            if (q.size() == 0) begin
                                check($sformatf("cfg%0d_unexpected", gi), 32'd1, 32'd0);
                            end else begin
                                e = q.pop_front();
                                check($sformatf("cfg%0d_diff", gi), 32'(xd), 32'(e[XW-1:0]));
                                check($sformatf("cfg%0d_bout", gi), 32'(xbo), 32'(e[XW]));
                            end
                        end
                        if (xiv && xir) begin
                            r  = int'(xa) - int'(xb) - int'(xbin);
                            dd = XW'(r);
`ifdef PIPE_SUB_SAT_EN
                            if (r < 0) dd = '0;
`endif
                            q.push_back({(r < 0), dd});
                        end
                    end
                end
            end
        end
    endgenerate

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int   acc;
    int   seen;
    logic hs;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed cases
        directed("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0);
        directed("xchunk", 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0);
`ifdef PIPE_SUB_SAT_EN
        directed("uflow", 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1);
`else
        directed("uflow", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
`endif

        // Back-pressure: fill under stall, then simultaneous in/out on a full pipe
        out_ready = 1'b0; acc = 0; new_op(); in_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin acc++; new_op(); end
        end
        check("bp_accepts", 32'(acc), 32'(S));
        @(negedge clk);
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_simul_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        acc++; new_op(); out_ready = 1'b0;
        @(negedge clk);
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_still_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && acc < 8; cyc++) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                acc++;
                if (acc < 8) new_op(); else in_valid = 1'b0;
            end
        end
        check("bp_total", 32'(acc), 32'd8);
        drain("bp_drain");

        // Full throughput
        out_ready = 1'b1; acc = 0; new_op(); in_valid = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1;
            if (hs) acc++;
            new_op();
        end
        in_valid = 1'b0;
        check("tput_accepts", 32'(acc), 32'd50);
        drain("tput_drain");

        // Random bubbles and back-pressure
        fork
            begin : in_side
                acc = 0;
                for (int cyc = 0; cyc < 20000 && acc < 1000; cyc++) begin
                    if (!in_valid && $urandom_range(0, 1) == 1) begin
                        in_valid = 1'b1; new_op();
                    end
                    @(negedge clk); hs = in_valid && in_ready;
                    @(posedge clk); #1;
                    if (hs) begin
                        acc++;
                        in_valid = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                        if (in_valid) new_op();
                    end
                end
                in_valid = 1'b0;
                check("rand_count", 32'(acc), 32'd1000);
                rand_done = 1'b1;
            end
            begin : out_side
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain("rand_drain");

        // Mid-stream asynchronous reset with 3 ops in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_op();
            @(negedge clk);
            check("mr_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mr_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_diff", 32'(diff), 32'd0);
        check("mr_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1; seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mr_no_ghost", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // Geometry sweep on the side instances
        sweep_go = 1'b1;
        for (int i = 0; i < 5000 && !(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done); i++) begin
            @(posedge clk);
        end
        #1;
        check("sweep_done", 32'(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_subtractor.md
# pipe_subtractor

Parametrised, pipelined multi-bit subtractor computing A − B − Bin over WIDTH bits. It is the multi-bit successor of the single-bit full subtractor: WIDTH is split into STAGES equal chunks, with one chunk resolved per pipeline stage and the borrow registered between stages. It sits in the datapath library as a streaming arithmetic element behind a valid/ready handshake and sustains one operation per cycle.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves CW = WIDTH/STAGES bits; STAGES ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- bin  input  1  borrow in.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  result A − B − Bin.
- bout  output  1  borrow out (1 when A < B + Bin).

## Operation
- One clock and one reset domain. Reset is asynchronous and active-high.
- Stage k (0..STAGES−1) holds: valid bit v[k]; borrow register br[k]; completed low result bits diff[(k+1)·CW−1:0]; pending high operand bits a, b above (k+1)·CW.
- Stage 0 captures on an input handshake: chunk 0 = a[CW−1:0] − b[CW−1:0] − bin. It stores the CW-bit result and borrow, plus the upper bits of a and b.
- Stage k>0 on advance: chunk k uses the delayed a/b chunk and br[k−1], appends the result to the accumulated low bits, and registers the new borrow.
- Per-stage bit rule is the full-subtractor identity: d = x ^ y ^ c; borrow = (~x & y) | (~(x ^ y) & c).
- Bubble-collapsing handshake: ready[k] = !v[k] | ready[k+1]; ready[STAGES] = out_ready; in_ready = ready[0].
- A stage loads when its upstream is valid and ready[k]=1. Otherwise it holds, or clears v[k] once its contents have moved downstream.
- Outputs: out_valid = v[STAGES−1]; diff/bout come from the last stage registers (no combinational path from a/b to diff).
- Arithmetic: unsigned modulo 2^WIDTH; bout = borrow from chunk STAGES−1.
- Ordering: results leave in acceptance order; no reordering or dropping.
- Reset (any time, including mid-stream): all v[k]=0, out_valid=0, diff=0, bout=0, all borrow/operand registers 0. In-flight operations are discarded. in_ready=1 while rst=0 and the pipe is empty.

## Timing
- Latency: operand accepted at edge t → out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles from acceptance to presentation.
- Throughput: 1 op/cycle when out_ready held 1.
- Stall: out_valid=1 & out_ready=0 → diff/bout/out_valid hold stable until the handshake.
- Bubbles ahead of a stalled output collapse. A full pipe under stall holds exactly STAGES operations, and in_ready=0.
- Simultaneous out handshake and in handshake on a full pipe: both complete in the same cycle; occupancy is unchanged.
- in_ready depends combinationally on out_ready through the v chain; no other combinational in→out paths.

## Configuration
- PIPE_SUB_SAT_EN defined: the final stage clamps the result as unsigned saturation. If the computed borrow out is 1, diff is 0. bout still reports 1.
- PIPE_SUB_SAT_EN undefined: diff wraps modulo 2^WIDTH (e.g. 0 − 1 → 0xFFFF for WIDTH=16).
- Latency, handshake and bout semantics are identical in both builds.

## Test plan
- Reset/basic (WIDTH=16, STAGES=4): after rst, a=0x1234, b=0x0034, bin=0, out_ready=1. Expect out_valid 4 cycles later with diff=0x1200, bout=0.
- Cross-chunk borrow: a=0x1000, b=0x0001, bin=1. Expect diff=0x0FFE, bout=0; the borrow ripples through chunks 0–2.
- Underflow: a=0x0000, b=0x0001, bin=0. Without PIPE_SUB_SAT_EN expect diff=0xFFFF, bout=1; with it, diff=0x0000, bout=1.
- Back-pressure: stream 8 random ops with out_ready=0. Expect in_ready to fall after exactly 4 accepts. Then release out_ready: all results arrive in order, matching the reference model, and diff stays stable while stalled.
- Bubbles and simultaneous events: alternate in_valid on/off with out_ready toggling randomly for 1000 ops. Expect no loss, duplication or reordering, and no drop in throughput when in and out handshakes occur in the same cycle.
- Mid-stream reset: assert rst asynchronously with 3 ops in flight. Expect out_valid=0, diff=0, bout=0 immediately and none of those ops emerging after release. Sweep configs STAGES=1,2,16 with WIDTH=16 and check exhaustively for WIDTH=4, STAGES=2.
